// File: rtl/vt_pkg.sv
// rtl/vt_pkg.sv - shared constants and write record for the character-VRAM path
package vt_pkg;

  localparam logic YES  = 1'b1;
  localparam logic NO   = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 7;
  localparam int BYTE_W = 8;

  localparam int RIGHT_COL = 99;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [BYTE_W-1:0] chr;
  } vram_write_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first valid requester after the start pointer
module rr_pick
  import vt_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [PW-1:0] c;
    c     = '0;
    grant = '0;
    idx   = '0;
    any   = NO;
    // start itself is checked last, so the previous winner yields to everyone else
    for (int k = 1; k <= N; k++) begin
      c = PW'((int'(start) + k) % N);
      if (!any && valid[c]) begin
        any      = YES;
        grant[c] = 1'b1;
        idx      = c;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - round-robin arbiter with burst lock sharing the VRAM write port
module vram_arbiter
  import vt_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset_low,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [ROW_W*NUM_REQ-1:0]  req_row,
  input  logic [COL_W*NUM_REQ-1:0]  req_col,
  input  logic [BYTE_W*NUM_REQ-1:0] req_byte,
  output logic                      vram_valid,
  input  logic                      vram_ready,
  output logic [ROW_W-1:0]          vram_row,
  output logic [COL_W-1:0]          vram_col,
  output logic [BYTE_W-1:0]         vram_byte,
  output logic [1:0]                vram_src,
  output logic                      busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      rr_ptr, owner, gidx, pick_idx;
  logic [3:0]         burst_cnt, burst_nxt;
  logic               lock, space, owner_hold, pick_any, xfer, contended;
  logic [NUM_REQ-1:0] pick_grant, grant;
  vram_write_t        slot [NUM_REQ];
  vram_write_t        out_q;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
    assign slot[i] = {req_row[ROW_W*i +: ROW_W], req_col[COL_W*i +: COL_W],
                      req_byte[BYTE_W*i +: BYTE_W]};

    a_hold: assert property (@(posedge clk) disable iff (!reset_low)
      req_valid[i] && !req_ready[i] |=> req_valid[i] && $stable(slot[i]));
    a_col: assert property (@(posedge clk) disable iff (!reset_low)
      req_valid[i] |-> slot[i].col <= COL_W'(RIGHT_COL));
  end

  rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .valid (req_valid),
    .start (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign space      = !vram_valid || vram_ready;
  assign owner_hold = lock && req_valid[owner];

  always_comb begin
    grant = pick_grant;
    gidx  = pick_idx;
    if (owner_hold) begin
      grant        = '0;
      grant[owner] = 1'b1;
      gidx         = owner;
    end
  end

  assign req_ready = (space && reset_low) ? grant : '0;
  assign xfer      = space && reset_low && (owner_hold || pick_any);
  assign contended = |(req_valid & ~grant);
  assign burst_nxt = (lock && gidx == owner) ? burst_cnt + 4'd1 : 4'd1;
  assign busy      = vram_valid || (|req_valid);

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      vram_valid <= LOW;
      out_q      <= '0;
      vram_src   <= '0;
      rr_ptr     <= PW'(NUM_REQ - 1);
      owner      <= '0;
      burst_cnt  <= '0;
      lock       <= NO;
    end else if (xfer) begin
      vram_valid <= HIGH;
      out_q      <= slot[gidx];
      vram_src   <= 2'(gidx);
      rr_ptr     <= gidx;
      // the lock only matters while someone else is waiting
      if (contended) begin
        owner     <= gidx;
        burst_cnt <= burst_nxt;
        lock      <= (burst_nxt != 4'(BURST_MAX));
      end else begin
        lock      <= NO;
        burst_cnt <= '0;
      end
    end else begin
      if (vram_ready) vram_valid <= LOW;
      if (lock && !req_valid[owner]) lock <= NO;
    end
  end

  assign vram_row  = out_q.row;
  assign vram_col  = out_q.col;
  assign vram_byte = out_q.chr;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single character-VRAM write port between several independent writers: the terminal engine, the status-line writer and the screen-clear engine.
- Each writer presents a ready/valid write of row, column and byte. The arbiter grants one writer per cycle, round-robin with a bounded burst lock.
- Accepted writes pass through a one-entry registered output stage that drives the VRAM write port.

Parameters:
- NUM_REQ, 3, number of requesters (2..4); index 0 is the terminal engine.
- BURST_MAX, 4, maximum consecutive transfers one requester may hold the grant while others are waiting (1..15).

Ports:
- clk  in  1  system clock.
- reset_low  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester write request.
- req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when valid and ready are both high.
- req_row  in  5*NUM_REQ  row of each request, packed with requester i at bits [5i+4:5i].
- req_col  in  7*NUM_REQ  column of each request (0..99), packed.
- req_byte  in  8*NUM_REQ  character of each request, packed.
- vram_valid  out  1  output write pending.
- vram_ready  in  1  VRAM accepts the pending write.
- vram_row  out  5  registered row.
- vram_col  out  7  registered column.
- vram_byte  out  8  registered byte.
- vram_src  out  2  index of the requester that owns the pending write.
- busy  out  1  high when vram_valid is high or any req_valid is high.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_low; the rest of the block is synchronous to clk.
- Reset values: vram_valid=0; vram_row/col/byte/src=0; rr_ptr=NUM_REQ-1; burst_cnt=0; lock=0; req_ready=0 while reset_low is low.
- Asserting reset mid-operation drops the pending write, with no partial state. The first grant after reset goes to requester 0.
- Buffer space: space = !vram_valid || vram_ready, computed combinationally.
- Grant selection, combinational, applied when space=1:
  - If lock=1 and req_valid[owner]=1, grant owner.
  - Otherwise grant the first valid requester scanning from rr_ptr+1 upward, modulo NUM_REQ.
- Ready rule: req_ready[i] = space && grant[i]. At most one req_ready is high per cycle. Ready does not depend on req_valid[i] except through the grant.
- On a transfer from requester g:
  - vram_row/col/byte are loaded from slice g and vram_src=g; vram_valid=1 next cycle.
  - rr_ptr<=g.
  - Latency: request accepted in cycle N appears on the VRAM port in cycle N+1.
- With no new transfer: if vram_ready && vram_valid, then vram_valid<=0. Output data holds while vram_valid && !vram_ready.
- Back-to-back throughput: when vram_ready is held high, one write per cycle, with no bubble.
- Burst lock:
  - On a transfer from g with another requester valid in the same cycle: if g==owner and lock=1, burst_cnt++; otherwise lock<=1, owner<=g, burst_cnt<=1.
  - When burst_cnt reaches BURST_MAX, lock<=0, so the next grant rotates.
  - If no other requester is valid, lock<=0 and burst_cnt<=0. An uncontended requester streams freely.
  - If the owner drops valid, the lock releases immediately and arbitration is round-robin in the same cycle.
- Simultaneous events:
  - Drain and accept in one cycle (vram_valid && vram_ready && a transfer) replaces the output contents; vram_valid stays 1.
  - All requesters valid with BURST_MAX=1 gives strict rotation 0,1,2,0…
- Requester obligations, checked by assertions in simulation: row, col and byte stay stable while valid && !ready; valid is not withdrawn before ready.
- Widths: slice indexing is by constant multiples. rr_ptr and owner are clog2(NUM_REQ) bits, zero-extended into vram_src. burst_cnt is 4 bits.

Decomposition:
- Shared package vt_pkg holds:
  - YES/NO and HIGH/LOW constants;
  - ROW_W=5, COL_W=7, BYTE_W=8;
  - RIGHT_COL=99;
  - typedef vram_write_t {row, col, byte}.
- One sub-module, rr_pick: pure combinational function from (valid mask, start pointer) to one-hot grant plus index. It is reused by the arbiter core and is unit-testable alone.

Test Plan:
- Reset: drive reset_low low mid-write with vram_valid=1 -> vram_valid=0 immediately (asynchronous). After release, with all req_valid high, req 0 is granted first.
- Single requester: req 1 writes (row 3, col 10, 'A') with vram_ready=1 -> req_ready[1]=1 the same cycle; the next cycle shows vram_valid=1, row=3, col=10, byte=0x41, src=1.
- Backpressure: vram_ready=0 for 5 cycles with req 0 valid -> one write is buffered, req_ready=0 throughout and the output is stable. When vram_ready rises, the buffered write drains and req 0 is accepted in the same cycle.
- Fairness: all three requesters valid continuously, BURST_MAX=4, vram_ready=1 -> grant order 0,0,0,0,1,1,1,1,2,2,2,2,0…
- Uncontended stream: only req 2 valid for 100 writes (a row clear of cols 0..99) -> 100 consecutive cycles with vram_valid=1. Req 0 then raising valid mid-stream gets its grant within 4 cycles.
- Owner drop: req 0 locked at burst_cnt=2 drops valid while req 1 is valid -> req 1 is granted the same cycle and lock is reassigned to req 1.
